// File: rtl/wash_pkg.sv
// Shared types and default timing constants for the wash phase timer.
package wash_pkg;

  // Program codes; a select of 3 decodes to normal.
  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2
  } prog_e;

  // Phase supervisor states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAULT = 3'd6
  } phase_e;

  // Bit positions of the control-FSM activity vector.
  localparam int ON_FILL  = 0;
  localparam int ON_WASH  = 1;
  localparam int ON_DRAIN = 2;
  localparam int ON_SPIN  = 3;

  localparam int TICK_DIV_DEF    = 100000;
  localparam int CNT_W_DEF       = 12;
  localparam int FILL_LIMIT_DEF  = 120;
  localparam int DRAIN_LIMIT_DEF = 90;

  // Phase durations in seconds.
  localparam int WASH_QUICK_DEF  = 300;
  localparam int WASH_NORMAL_DEF = 900;
  localparam int WASH_HEAVY_DEF  = 1500;
  localparam int SPIN_QUICK_DEF  = 120;
  localparam int SPIN_NORMAL_DEF = 300;
  localparam int SPIN_HEAVY_DEF  = 600;

  function automatic prog_e decode_prog(input logic [1:0] sel);
    return (sel == 2'd3) ? PROG_NORMAL : prog_e'(sel);
  endfunction

endpackage

// File: rtl/wash_tick_prescaler.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module wash_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer/watchdog beside the washer control FSM: generates wash and spin
// timeouts from the latched program and faults on fill/drain overrun or on
// overlapping phase requests.
module wash_phase_timer
  import wash_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int FILL_LIMIT  = FILL_LIMIT_DEF,
  parameter int DRAIN_LIMIT = DRAIN_LIMIT_DEF,
  parameter int WASH_QUICK  = WASH_QUICK_DEF,
  parameter int WASH_NORMAL = WASH_NORMAL_DEF,
  parameter int WASH_HEAVY  = WASH_HEAVY_DEF,
  parameter int SPIN_QUICK  = SPIN_QUICK_DEF,
  parameter int SPIN_NORMAL = SPIN_NORMAL_DEF,
  parameter int SPIN_HEAVY  = SPIN_HEAVY_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       prog_sel,
  input  logic             prog_load,
  input  logic             door_lock,
  input  logic             fill_on,
  input  logic             wash_on,
  input  logic             drain_on,
  input  logic             spin_on,
  input  logic             fault_clr,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  logic             tick;
  logic [3:0]       on, on_q, rise;
  logic             multi, door_q, door_fall;
  prog_e            prog;
  phase_e           state, state_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic             done_spin, done_spin_d;
  logic [CNT_W-1:0] wash_time, spin_time;
  logic             enter;
  phase_e           enter_state;
  logic [CNT_W-1:0] enter_rem;
  logic             own, expire;

  wash_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign on        = {spin_on, drain_on, wash_on, fill_on};
  assign rise      = on & ~on_q;
  assign multi     = (on & (on - 4'd1)) != 4'd0;
  assign door_fall = door_q && !door_lock;

  // Input history for edge detection and the program latch (idle-only loads).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      on_q   <= '0;
      door_q <= 1'b0;
      prog   <= PROG_NORMAL;
    end else begin
      on_q   <= on;
      door_q <= door_lock;
      if (prog_load && !door_lock) prog <= decode_prog(prog_sel);
    end
  end

  // Duration table lookup for the latched program.
  always_comb begin
    wash_time = CNT_W'(WASH_NORMAL);
    spin_time = CNT_W'(SPIN_NORMAL);
    case (prog)
      PROG_QUICK: begin wash_time = CNT_W'(WASH_QUICK); spin_time = CNT_W'(SPIN_QUICK); end
      PROG_HEAVY: begin wash_time = CNT_W'(WASH_HEAVY); spin_time = CNT_W'(SPIN_HEAVY); end
      default:    ;
    endcase
  end

  // Phase entered by a single rising request, with its load value.
  always_comb begin
    enter       = 1'b1;
    enter_state = ST_IDLE;
    enter_rem   = '0;
    if (rise[ON_FILL])       begin enter_state = ST_FILL;  enter_rem = CNT_W'(FILL_LIMIT);  end
    else if (rise[ON_WASH])  begin enter_state = ST_WASH;  enter_rem = wash_time;           end
    else if (rise[ON_DRAIN]) begin enter_state = ST_DRAIN; enter_rem = CNT_W'(DRAIN_LIMIT); end
    else if (rise[ON_SPIN])  begin enter_state = ST_SPIN;  enter_rem = spin_time;           end
    else                     enter = 1'b0;
  end

  // Activity bit owning the current phase, and countdown expiry this clock.
  always_comb begin
    own = 1'b0;
    case (state)
      ST_FILL:  own = fill_on;
      ST_WASH:  own = wash_on;
      ST_DRAIN: own = drain_on;
      ST_SPIN:  own = spin_on;
      ST_DONE:  own = done_spin ? spin_on : wash_on;
      default:  own = 1'b0;
    endcase
    expire = (rem == '0) || (tick && rem == CNT_W'(1));
  end

  // Next-state and countdown logic.
  always_comb begin
    state_d     = state;
    rem_d       = rem;
    done_spin_d = done_spin;
    if (multi && state != ST_FAULT) begin
      state_d = ST_FAULT;
      rem_d   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enter) begin
            state_d = enter_state;
            rem_d   = enter_rem;
          end
        end
        ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
          if (door_fall) begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end else if (!own) begin
            // Leaving a phase; a simultaneous new request is entered directly.
            state_d = enter ? enter_state : ST_IDLE;
            rem_d   = enter ? enter_rem : '0;
          end else if (expire) begin
            rem_d = '0;
            if (state == ST_FILL || state == ST_DRAIN) begin
              state_d = ST_FAULT;
            end else begin
              state_d     = ST_DONE;
              done_spin_d = (state == ST_SPIN);
            end
          end else if (tick) begin
            rem_d = rem - 1'b1;
          end
        end
        ST_DONE: begin
          if (!own) begin
            state_d = enter ? enter_state : ST_IDLE;
            rem_d   = enter ? enter_rem : '0;
          end
        end
        ST_FAULT: begin
          rem_d = '0;
          if (fault_clr && !door_lock) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // State, countdown and finished-phase kind registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rem       <= '0;
      done_spin <= 1'b0;
    end else begin
      state     <= state_d;
      rem       <= rem_d;
      done_spin <= done_spin_d;
    end
  end

  assign cycle_timeout = (state == ST_DONE) && !done_spin;
  assign spin_timeout  = (state == ST_DONE) &&  done_spin;
  assign fault         = (state == ST_FAULT);
  assign busy          = (state == ST_FILL) || (state == ST_WASH) ||
                         (state == ST_DRAIN) || (state == ST_SPIN);
  assign remaining     = rem;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with a 4-clock tick and short durations.
module tb_wash_phase_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  prog_sel;
  logic        prog_load, door_lock, fill_on, wash_on, drain_on, spin_on, fault_clr;
  logic        cycle_timeout, spin_timeout, fault, busy;
  logic [11:0] remaining;

  int errors = 0;
  int checks = 0;

  wash_phase_timer #(
    .TICK_DIV(4), .CNT_W(12), .FILL_LIMIT(5), .DRAIN_LIMIT(4),
    .WASH_QUICK(3), .WASH_NORMAL(4), .WASH_HEAVY(6),
    .SPIN_QUICK(2), .SPIN_NORMAL(3), .SPIN_HEAVY(4)
  ) dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .prog_load(prog_load),
    .door_lock(door_lock), .fill_on(fill_on), .wash_on(wash_on),
    .drain_on(drain_on), .spin_on(spin_on), .fault_clr(fault_clr),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .fault(fault), .busy(busy), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    prog_sel = 2'd0; prog_load = 0; door_lock = 0;
    fill_on = 0; wash_on = 0; drain_on = 0; spin_on = 0; fault_clr = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with inputs idle; returns at a negedge with the prescaler at 0.
  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step(2);
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    step(2);
    checks++;
    if ({cycle_timeout, spin_timeout, fault, busy, remaining} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {cycle_timeout, spin_timeout, fault, busy, remaining});
    end
    reset = 1;
    step(1);
    checks++;
    if ({cycle_timeout, spin_timeout, fault, busy, remaining} !== 16'h0) begin
      errors++; $display("FAIL post_reset_outputs: got %h expected 0", {cycle_timeout, spin_timeout, fault, busy, remaining});
    end
  endtask

  // Quick wash of 3 s: timeout the clock after the 3rd tick, cleared by wash_on low.
  task automatic test_wash_timeout();
    do_reset();
    prog_sel = 2'd0; prog_load = 1;
    step(1);
    prog_load = 0; door_lock = 1; wash_on = 1;
    step(1);
    checks++;
    if (busy !== 1'b1 || remaining !== 12'd3) begin
      errors++; $display("FAIL wash_load: got busy=%0b rem=%0d expected busy=1 rem=3", busy, remaining);
    end
    step(9);
    checks++;
    if (cycle_timeout !== 1'b0 || remaining !== 12'd1) begin
      errors++; $display("FAIL wash_before_end: got to=%0b rem=%0d expected to=0 rem=1", cycle_timeout, remaining);
    end
    step(1);
    checks++;
    if (cycle_timeout !== 1'b1 || remaining !== 12'd0 || busy !== 1'b0 || spin_timeout !== 1'b0) begin
      errors++; $display("FAIL wash_timeout: got to=%0b sto=%0b rem=%0d busy=%0b expected 1 0 0 0", cycle_timeout, spin_timeout, remaining, busy);
    end
    step(2);
    checks++;
    if (cycle_timeout !== 1'b1) begin
      errors++; $display("FAIL wash_timeout_hold: got %0b expected 1", cycle_timeout);
    end
    wash_on = 0;
    step(1);
    checks++;
    if (cycle_timeout !== 1'b0 || busy !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL wash_release: got to=%0b busy=%0b fault=%0b expected 0 0 0", cycle_timeout, busy, fault);
    end
  endtask

  // Normal spin of 3 s raises spin_timeout only.
  task automatic test_spin_timeout();
    do_reset();
    door_lock = 1; spin_on = 1;
    step(11);
    checks++;
    if (spin_timeout !== 1'b0 || remaining !== 12'd1) begin
      errors++; $display("FAIL spin_before_end: got sto=%0b rem=%0d expected 0 1", spin_timeout, remaining);
    end
    step(1);
    checks++;
    if (spin_timeout !== 1'b1 || cycle_timeout !== 1'b0) begin
      errors++; $display("FAIL spin_timeout: got sto=%0b to=%0b expected 1 0", spin_timeout, cycle_timeout);
    end
    spin_on = 0;
    step(1);
    checks++;
    if (spin_timeout !== 1'b0) begin
      errors++; $display("FAIL spin_release: got %0b expected 0", spin_timeout);
    end
  endtask

  // Fill overrun after 5 ticks faults; clear honoured only with door unlocked.
  task automatic test_fill_watchdog();
    do_reset();
    door_lock = 1; fill_on = 1;
    step(1);
    checks++;
    if (remaining !== 12'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL fill_load: got rem=%0d busy=%0b expected 5 1", remaining, busy);
    end
    step(18);
    checks++;
    if (fault !== 1'b0 || remaining !== 12'd1) begin
      errors++; $display("FAIL fill_before_limit: got fault=%0b rem=%0d expected 0 1", fault, remaining);
    end
    step(1);
    checks++;
    if (fault !== 1'b1 || remaining !== 12'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL fill_fault: got fault=%0b rem=%0d busy=%0b expected 1 0 0", fault, remaining, busy);
    end
    step(4);
    fill_on = 0; fault_clr = 1;
    step(2);
    checks++;
    if (fault !== 1'b1) begin
      errors++; $display("FAIL fault_clr_locked: got %0b expected 1", fault);
    end
    door_lock = 0;
    step(1);
    fault_clr = 0;
    checks++;
    if (fault !== 1'b0) begin
      errors++; $display("FAIL fault_clr_unlocked: got %0b expected 0", fault);
    end
  endtask

  // Overlapping requests fault at once, from idle and from a running phase.
  task automatic test_overlap();
    do_reset();
    door_lock = 1; wash_on = 1; drain_on = 1;
    step(1);
    checks++;
    if (fault !== 1'b1 || cycle_timeout !== 1'b0 || spin_timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL overlap_idle: got fault=%0b to=%0b sto=%0b busy=%0b expected 1 0 0 0", fault, cycle_timeout, spin_timeout, busy);
    end
    do_reset();
    door_lock = 1; wash_on = 1;
    step(1);
    drain_on = 1;
    step(1);
    checks++;
    if (fault !== 1'b1 || remaining !== 12'd0) begin
      errors++; $display("FAIL overlap_wash: got fault=%0b rem=%0d expected 1 0", fault, remaining);
    end
  endtask

  // Door unlock during spin aborts; spin_timeout never follows.
  task automatic test_abort();
    int seen;
    seen = 0;
    do_reset();
    door_lock = 1; spin_on = 1;
    step(4);
    checks++;
    if (remaining !== 12'd2) begin
      errors++; $display("FAIL abort_pre: got rem=%0d expected 2", remaining);
    end
    door_lock = 0;
    step(1);
    checks++;
    if (busy !== 1'b0 || remaining !== 12'd0 || fault !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%0b rem=%0d fault=%0b expected 0 0 0", busy, remaining, fault);
    end
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (spin_timeout !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_timeout: got %0d cycles high expected 0", seen);
    end
  endtask

  // Direct phase hand-offs: fill->wash, wash->drain, drain dropped early.
  task automatic test_back_to_back();
    do_reset();
    door_lock = 1; fill_on = 1;
    step(1);
    fill_on = 0; wash_on = 1;
    step(1);
    checks++;
    if (busy !== 1'b1 || remaining !== 12'd4 || fault !== 1'b0) begin
      errors++; $display("FAIL fill_to_wash: got busy=%0b rem=%0d fault=%0b expected 1 4 0", busy, remaining, fault);
    end
    wash_on = 0; drain_on = 1;
    step(1);
    checks++;
    if (busy !== 1'b1 || remaining !== 12'd4 || cycle_timeout !== 1'b0) begin
      errors++; $display("FAIL wash_to_drain: got busy=%0b rem=%0d to=%0b expected 1 4 0", busy, remaining, cycle_timeout);
    end
    drain_on = 0;
    step(1);
    checks++;
    if (busy !== 1'b0 || fault !== 1'b0 || remaining !== 12'd0) begin
      errors++; $display("FAIL drain_early: got busy=%0b fault=%0b rem=%0d expected 0 0 0", busy, fault, remaining);
    end
  endtask

  // Program loads ignored while locked; applied at the next phase load.
  task automatic test_prog_lock();
    do_reset();
    door_lock = 1; prog_sel = 2'd2; prog_load = 1;
    step(1);
    prog_load = 0; wash_on = 1;
    step(1);
    checks++;
    if (remaining !== 12'd4) begin
      errors++; $display("FAIL prog_locked: got rem=%0d expected 4", remaining);
    end
    wash_on = 0; door_lock = 0; prog_load = 1;
    step(1);
    prog_load = 0; door_lock = 1; wash_on = 1;
    step(1);
    checks++;
    if (remaining !== 12'd6) begin
      errors++; $display("FAIL prog_heavy: got rem=%0d expected 6", remaining);
    end
    wash_on = 0; door_lock = 0; prog_sel = 2'd3; prog_load = 1;
    step(1);
    prog_load = 0; door_lock = 1; wash_on = 1;
    step(1);
    checks++;
    if (remaining !== 12'd4) begin
      errors++; $display("FAIL prog_sel3: got rem=%0d expected 4", remaining);
    end
  endtask

  // Asynchronous reset mid-wash clears outputs immediately and restores normal.
  task automatic test_async_reset();
    do_reset();
    prog_sel = 2'd0; prog_load = 1;
    step(1);
    prog_load = 0; door_lock = 1; wash_on = 1;
    step(2);
    checks++;
    if (busy !== 1'b1 || remaining !== 12'd3) begin
      errors++; $display("FAIL areset_pre: got busy=%0b rem=%0d expected 1 3", busy, remaining);
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({cycle_timeout, spin_timeout, fault, busy, remaining} !== 16'h0) begin
      errors++; $display("FAIL areset_outputs: got %h expected 0", {cycle_timeout, spin_timeout, fault, busy, remaining});
    end
    @(negedge clk);
    reset = 1;
    step(1);
    checks++;
    if (busy !== 1'b1 || remaining !== 12'd4) begin
      errors++; $display("FAIL areset_prog_normal: got busy=%0b rem=%0d expected 1 4", busy, remaining);
    end
  endtask

  initial begin
    test_reset();
    test_wash_timeout();
    test_spin_timeout();
    test_fill_watchdog();
    test_overlap();
    test_abort();
    test_back_to_back();
    test_prog_lock();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
